// File: rtl/count_dir_pkg.sv
// count_dir_pkg: shared FSM state and step class encodings
package count_dir_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        UP   = 2'd0,
        DOWN = 2'd1,
        HOLD = 2'd2,
        BAD  = 2'd3
    } step_e;

endpackage

// File: rtl/step_classifier.sv
// step_classifier: classifies the modulo-2^N difference between two samples
module step_classifier
    import count_dir_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] prev,
    input  logic [N-1:0] cur,
    output step_e        cls
);

    logic [N-1:0] delta;

    // delta wraps naturally in N bits, so 3->0 reads as +1 and 0->3 as -1
    always_comb begin
        delta = cur - prev;
        cls = (delta == N'(1))      ? UP   :
              (delta == {N{1'b1}})  ? DOWN :
              (delta == '0)         ? HOLD : BAD;
    end

endmodule

// File: rtl/count_direction_detector.sv
// count_direction_detector: recovers up/down direction from an observed count stream
module count_direction_detector
    import count_dir_pkg::*;
#(
    parameter int N        = 2,
    parameter int LOCK_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic [N-1:0] count_in,
    output logic         up_or_down,
    output logic         locked,
    output logic         step_err,
    output logic         dir_change,
    output logic         stall
);

    step_e        cls;
    state_e       state_q, state_d;
    logic [3:0]   run_q, run_d, run_nx;
    logic [N-1:0] prev_q, prev_d;
    logic         cand_q, cand_d;
    logic         up_q, up_d;
    logic         locked_q, locked_d;
    logic         err_q, err_d;
    logic         chg_q, chg_d;
    logic         stall_q, stall_d;
    logic         is_step, step_dir;

    step_classifier #(.N(N)) u_cls (
        .prev (prev_q),
        .cur  (count_in),
        .cls  (cls)
    );

    // next-state: acquire a run of same-direction steps, then track reversals while locked
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        prev_d   = prev_q;
        cand_d   = cand_q;
        up_d     = up_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        chg_d    = 1'b0;
        stall_d  = 1'b0;
        is_step  = (cls == UP) || (cls == DOWN);
        step_dir = (cls == UP);
        run_nx   = (run_q == 4'd0 || step_dir == cand_q) ? run_q + 4'd1 : 4'd1;
        if (sample_en) begin
            prev_d = count_in;
            case (state_q)
                EMPTY: begin
                    run_d   = 4'd0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (is_step) begin
                        run_d  = run_nx;
                        cand_d = step_dir;
                        if (run_nx == 4'(LOCK_LEN)) begin
                            state_d  = LOCKED;
                            up_d     = step_dir;
                            locked_d = 1'b1;
                        end
                    end else if (cls == HOLD) begin
                        stall_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_step) begin
                        chg_d = step_dir != up_q;
                        up_d  = step_dir;
                    end else if (cls == HOLD) begin
                        stall_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        run_d    = 4'd0;
                        state_d  = ACQ;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // state and output registers; reset discards the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            run_q    <= 4'd0;
            prev_q   <= '0;
            cand_q   <= 1'b1;
            up_q     <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            chg_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
            cand_q   <= cand_d;
            up_q     <= up_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            chg_q    <= chg_d;
            stall_q  <= stall_d;
        end
    end

    assign up_or_down = up_q;
    assign locked     = locked_q;
    assign step_err   = err_q;
    assign dir_change = chg_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_count_direction_detector.sv
// tb_count_direction_detector: scoreboard bench against a step-history reference model
module tb_count_direction_detector;

    localparam int N = 2;
    localparam int L = 2;
    localparam int M = 1 << N;

    typedef struct packed {
        logic up;
        logic lk;
        logic err;
        logic chg;
        logic stl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sample_en = 1'b0;
    logic [N-1:0] count_in = '0;
    logic         up_or_down, locked, step_err, dir_change, stall;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bit   have_prev = 0;
    int   m_prev = 0;
    bit   m_lock = 0;
    bit   m_dir = 1;
    bit   hist[$];
    int   cur = 0;

    count_direction_detector #(.N(N), .LOCK_LEN(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .count_in   (count_in),
        .up_or_down (up_or_down),
        .locked     (locked),
        .step_err   (step_err),
        .dir_change (dir_change),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Model: locked once the last L direction steps since the last break agree;
    // once locked, direction follows every step until an illegal step breaks the lock.
    task automatic step(input bit r, input bit en, input int c);
        exp_t e;
        int   dl;
        int   same;
        bit   d;
        @(negedge clk);
        rst = r;
        sample_en = en;
        count_in = N'(c);
        e = '0;
        if (r) begin
            have_prev = 0;
            m_lock = 0;
            m_dir = 1;
            hist.delete();
        end else if (en) begin
            if (have_prev) begin
                dl = (((c - m_prev) % M) + M) % M;
                if (dl == 1 || dl == M - 1) begin
                    d = (dl == 1);
                    if (m_lock) begin
                        e.chg = (d != m_dir);
                        m_dir = d;
                    end else begin
                        hist.push_back(d);
                        if (hist.size() > L) void'(hist.pop_front());
                        same = 0;
                        foreach (hist[i]) if (hist[i] == d) same++;
                        if (same == L) begin
                            m_lock = 1;
                            m_dir = d;
                        end
                    end
                end else if (dl == 0) begin
                    e.stl = 1;
                end else begin
                    e.err = 1;
                    m_lock = 0;
                    hist.delete();
                end
            end
            have_prev = 1;
            m_prev = c;
            cur = c;
        end
        e.up = m_dir;
        e.lk = m_lock;
        exp_q.push_back(e);
    endtask

    task automatic seq(input int a, input int b, input int c2, input int d2, input int e2);
        step(0, 1, a);
        step(0, 1, b);
        step(0, 1, c2);
        step(0, 1, d2);
        step(0, 1, e2);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom_range(M - 1));
    endtask

    // monitor: every clock presents a fresh output word; compare against the oldest expectation
    initial begin : monitor
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{up_or_down, locked, step_err, dir_change, stall};
                checks++;
                if (g !== e)
                    begin
                        errors++;
                        $display("FAIL outs cyc=%0d got up=%b lk=%b err=%b chg=%b stl=%b exp up=%b lk=%b err=%b chg=%b stl=%b",
                                 cyc, g.up, g.lk, g.err, g.chg, g.stl, e.up, e.lk, e.err, e.chg, e.stl);
                    end
            end
        end
    end

    initial begin : driver
        int r;
        step(1, 0, 0);
        step(1, 1, 2);
        seq(0, 1, 2, 3, 0);
        step(0, 1, 1);
        step(0, 1, 2);
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 2);
        step(0, 1, 3);
        step(0, 1, 0);
        step(0, 1, 1);
        step(1, 1, 3);
        step(0, 1, 1);
        step(0, 1, 2);
        step(1, 0, 0);
        seq(3, 2, 1, 0, 3);
        step(1, 0, 0);
        step(0, 1, 1);
        gap(3);
        step(0, 1, 1);
        gap(3);
        step(0, 1, 2);
        gap(3);
        step(0, 1, 2);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            if (r < 2)        step(1, $urandom_range(1), $urandom_range(M - 1));
            else if (r < 15)  step(0, 0, $urandom_range(M - 1));
            else if (r < 55)  step(0, 1, (cur + 1) % M);
            else if (r < 75)  step(0, 1, (cur + M - 1) % M);
            else if (r < 88)  step(0, 1, cur);
            else              step(0, 1, $urandom_range(M - 1));
        end
        step(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
